// File: rtl/pc_unit.sv
// Program-counter unit for the multi-phase core: fetch-step, writeback redirects, exception PC.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
    parameter int unsigned    W         = 32,
    parameter int unsigned    PHASE_W   = 3,
    parameter int unsigned    FETCH_PH  = 0,
    parameter int unsigned    WB_PH     = 4,
    parameter int unsigned    STEP      = 4,
    parameter logic [W-1:0]   RESET_VEC = '0,
    parameter logic [W-1:0]   TRAP_VEC  = W'('h80),
    parameter int unsigned    RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [PHASE_W-1:0] phase,
    input  logic               stall,
    input  logic               ct_taken,
    input  logic               ct_rel,
    input  logic [W-1:0]       dr,
    input  logic               trap,
    input  logic               eret,
    input  logic               call,
    input  logic               ret,
    output logic [W-1:0]       pc,
    output logic [W-1:0]       ipc,
    output logic [W-1:0]       epc,
    output logic               misalign,
    output logic               ras_empty
);

    localparam logic [W-1:0]       StepW   = W'(STEP);
    localparam logic [PHASE_W-1:0] FetchPh = PHASE_W'(FETCH_PH);
    localparam logic [PHASE_W-1:0] WbPh    = PHASE_W'(WB_PH);

    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] ipc_q, ipc_d;
    logic [W-1:0] epc_q, epc_d;

    logic         is_fetch;
    logic         is_wb;
    logic [W-1:0] ct_target;
    logic         ras_pop;
    logic [W-1:0] ras_top;

    assign is_fetch  = !stall && (phase == FetchPh);
    assign is_wb     = !stall && (phase == WbPh);
    assign ct_target = ct_rel ? (ipc_q + dr) : dr;

`ifdef PC_RAS_EN
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);

    logic [W-1:0]    ras_q [RAS_DEPTH];
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW:0]   cnt_q, cnt_d;
    logic            ras_op;
    logic            ras_push;
    logic            ras_wr_en;
    logic [PtrW-1:0] ras_wr_idx;

    // Stack only moves on a taken transfer that is not pre-empted by trap/eret.
    assign ras_op   = is_wb && !trap && !eret && ct_taken;
    assign ras_pop  = ras_op && ret && (cnt_q != '0);
    assign ras_push = ras_op && call;
    assign ras_top  = ras_q[ptr_q];

    always_comb begin
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        ras_wr_en  = 1'b0;
        ras_wr_idx = ptr_q;
        if (ras_pop && ras_push) begin
            // Pop-then-push collapses to overwriting the top entry in place.
            ras_wr_en = 1'b1;
        end else if (ras_pop) begin
            ptr_d = ptr_q - PtrW'(1);
            cnt_d = cnt_q - (PtrW+1)'(1);
        end else if (ras_push) begin
            ptr_d      = ptr_q + PtrW'(1);
            ras_wr_idx = ptr_q + PtrW'(1);
            ras_wr_en  = 1'b1;
            if (cnt_q != (PtrW+1)'(RAS_DEPTH)) begin
                cnt_d = cnt_q + (PtrW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents are don't-care while the count excludes them, so no reset.
    always_ff @(posedge clk) begin
        if (ras_wr_en) begin
            ras_q[ras_wr_idx] <= ipc_q + StepW;
        end
    end

    assign ras_empty = (cnt_q == '0);
`else
    logic unused_ras;

    assign ras_pop    = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign unused_ras = call ^ ret ^ (RAS_DEPTH == 0);
`endif

    always_comb begin
        pc_d  = pc_q;
        ipc_d = ipc_q;
        epc_d = epc_q;
        if (is_fetch) begin
            ipc_d = pc_q;
            pc_d  = pc_q + StepW;
        end else if (is_wb) begin
            if (trap) begin
                epc_d = ipc_q;
                pc_d  = TRAP_VEC;
            end else if (eret) begin
                pc_d = epc_q;
            end else if (ct_taken) begin
                pc_d = ras_pop ? ras_top : ct_target;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pc_q  <= RESET_VEC;
            ipc_q <= RESET_VEC;
            epc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ipc_q <= ipc_d;
            epc_q <= epc_d;
        end
    end

    assign pc  = pc_q;
    assign ipc = ipc_q;
    assign epc = epc_q;

    generate
        if (STEP > 1) begin : g_misalign
            assign misalign = |pc_q[$clog2(STEP)-1:0];
        end else begin : g_no_misalign
            assign misalign = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model (RAS modelled when PC_RAS_EN is defined).
module tb_pc_unit;

    localparam int unsigned STEP  = 4;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [2:0]  phase;
    logic        stall, ct_taken, ct_rel, trap, eret, call, ret;
    logic [31:0] dr;
    logic [31:0] pc, ipc, epc;
    logic        misalign, ras_empty;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_pc, m_ipc, m_epc;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_unit dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .phase    (phase),
        .stall    (stall),
        .ct_taken (ct_taken),
        .ct_rel   (ct_rel),
        .dr       (dr),
        .trap     (trap),
        .eret     (eret),
        .call     (call),
        .ret      (ret),
        .pc       (pc),
        .ipc      (ipc),
        .epc      (epc),
        .misalign (misalign),
        .ras_empty(ras_empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_ipc = 32'h0;
        m_epc = 32'h0;
        m_ras.delete();
    endtask

    // One clock edge of the architectural rules, using the inputs held across that edge.
    task automatic model_step();
        logic [31:0] tgt;
        if (!n_rst) begin
            model_reset();
        end else if (!stall) begin
            if (phase == 3'd0) begin
                m_ipc = m_pc;
                m_pc  = m_pc + STEP;
            end else if (phase == 3'd4) begin
                if (trap) begin
                    m_epc = m_ipc;
                    m_pc  = 32'h80;
                end else if (eret) begin
                    m_pc = m_epc;
                end else if (ct_taken) begin
                    tgt = ct_rel ? m_ipc + dr : dr;
`ifdef PC_RAS_EN
                    if (ret && m_ras.size() > 0) tgt = m_ras.pop_back();
                    if (call) begin
                        m_ras.push_back(m_ipc + STEP);
                        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    end
`endif
                    m_pc = tgt;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic exp_empty;
`ifdef PC_RAS_EN
        exp_empty = (m_ras.size() == 0);
`else
        exp_empty = 1'b1;
`endif
        check("pc", pc, m_pc);
        check("ipc", ipc, m_ipc);
        check("epc", epc, m_epc);
        check("misalign", {31'b0, misalign}, {31'b0, (m_pc % STEP) != 0});
        check("ras_empty", {31'b0, ras_empty}, {31'b0, exp_empty});
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        compare_all();
    endtask

    task automatic op(input logic [2:0] ph, input logic st, input logic ct, input logic rel,
                      input logic [31:0] d, input logic tr, input logic er, input logic ca,
                      input logic re);
        phase = ph; stall = st; ct_taken = ct; ct_rel = rel; dr = d;
        trap = tr; eret = er; call = ca; ret = re;
        cycle();
    endtask

    task automatic fetch();
        op(3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wb_ct(input logic rel, input logic [31:0] d, input logic ca, input logic re);
        op(3'd4, 1'b0, 1'b1, rel, d, 1'b0, 1'b0, ca, re);
    endtask

    initial begin
        phase = 3'd0; stall = 1'b0; ct_taken = 1'b0; ct_rel = 1'b0; dr = 32'h0;
        trap = 1'b0; eret = 1'b0; call = 1'b0; ret = 1'b0;
        n_rst = 1'b0;
        model_reset();
        #2 n_rst = 1'b1;
        // Async reset between edges after one fetch edge at 5 ns.
        #6 n_rst = 1'b0;
        #1;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_ipc", ipc, 32'h0);
        check("async_rst_epc", epc, 32'h0);
        #12 n_rst = 1'b1;
        cycle();
        check("fetch1", pc, 32'h4);
        fetch(); check("fetch2", pc, 32'h8);
        fetch(); check("fetch3", pc, 32'hC);

        fetch(); fetch();
        check("ipc_pre_br", ipc, 32'h10);
        wb_ct(1'b0, 32'h100, 1'b0, 1'b0);
        check("br_abs", pc, 32'h100);
        fetch();
        wb_ct(1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0);
        check("br_rel", pc, 32'hF0);

        wb_ct(1'b0, 32'h24, 1'b0, 1'b0);
        fetch();
        op(3'd4, 1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        check("trap_pc", pc, 32'h80);
        check("trap_epc", epc, 32'h24);
        fetch();
        op(3'd4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("eret_pc", pc, 32'h24);

        wb_ct(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        op(3'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stall_pc", pc, 32'hFFFF_FFFC);
        fetch();
        check("wrap_pc", pc, 32'h0);
        check("wrap_ipc", ipc, 32'hFFFF_FFFC);

        wb_ct(1'b0, 32'h102, 1'b0, 1'b0);
        check("mis_pc", pc, 32'h102);
        check("mis_flag", {31'b0, misalign}, 32'h1);
        fetch();
        check("mis_pc2", pc, 32'h106);
        check("mis_flag2", {31'b0, misalign}, 32'h1);

`ifdef PC_RAS_EN
        wb_ct(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            fetch();
            wb_ct(1'b0, 32'(i + 1) * 32'h10, 1'b1, 1'b0);
        end
        check("ras_nonempty", {31'b0, ras_empty}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            fetch();
            wb_ct(1'b0, 32'h300, 1'b0, 1'b1);
            check("ras_ret", pc, 32'h44 - 32'(k) * 32'h10);
        end
        fetch();
        wb_ct(1'b0, 32'h200, 1'b0, 1'b1);
        check("ras_ret_empty", pc, 32'h200);
        check("ras_empty_end", {31'b0, ras_empty}, 32'h1);
`endif

        for (int n = 0; n < 3000; n++) begin
            logic [2:0] ph;
            int sel;
            sel = $urandom_range(0, 9);
            ph = (sel < 4) ? 3'd0 : (sel < 8) ? 3'd4 : 3'($urandom_range(0, 7));
            op(ph, ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1,
               ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255)) << 2,
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 499) == 0) begin
                n_rst = 1'b0;
                cycle();
                n_rst = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the multi-phase (fetch … writeback) non-pipelined core; successor to the fixed 32-bit pc block.
- Fetch phase: advances by a configurable step.
- Writeback phase: applies redirects from control transfer, trap entry and exception return.
- Keeps the current-instruction address and an exception PC.
- Optional return-address stack.

Parameters:
- W, 32, PC/data width in bits
- PHASE_W, 3, width of phase input
- FETCH_PH, 0, phase code for fetch
- WB_PH, 4, phase code for writeback
- STEP, 4, sequential increment; power of two ≥ 1
- RESET_VEC, 0, PC value after reset
- TRAP_VEC, 'h80, trap entry address
- RAS_DEPTH, 4, return-address stack entries; power of two ≥ 2; used only with PC_RAS_EN

Ports:
- clk  in  1  clock; rising edge
- n_rst  in  1  asynchronous active-low reset
- phase  in  PHASE_W  current core phase
- stall  in  1  freezes all state this cycle
- ct_taken  in  1  control transfer taken; sampled in WB_PH
- ct_rel  in  1  1: target = ipc + dr; 0: target = dr
- dr  in  W  branch target or offset
- trap  in  1  trap request; sampled in WB_PH
- eret  in  1  exception return; sampled in WB_PH
- call  in  1  transfer is a call (RAS push)
- ret  in  1  transfer is a return (RAS pop)
- pc  out  W  next fetch address (registered)
- ipc  out  W  address of instruction in flight (registered)
- epc  out  W  exception PC (registered)
- misalign  out  1  combinational; |pc[log2(STEP)-1:0]; constant 0 when STEP=1
- ras_empty  out  1  registered; RAS holds no entries

Behaviour:
- Reset (n_rst low, asynchronous, any phase):
  - pc = RESET_VEC; ipc = RESET_VEC; epc = 0
  - RAS pointer and count = 0; ras_empty = 1
- stall=1: no register changes, regardless of phase or other inputs.
- phase==FETCH_PH, !stall: ipc <= pc; pc <= pc + STEP. Result truncated mod 2^W, so the top address wraps to 0.
- phase==WB_PH, !stall: fixed priority, one action per cycle.
  - 1. trap: epc <= ipc; pc <= TRAP_VEC.
  - 2. eret: pc <= epc.
  - 3. ct_taken: pc <= (ct_rel ? ipc + dr : dr). Addition mod 2^W; dr is two's-complement in relative mode.
  - 4. None of the above: pc holds its fetch-incremented value.
- Any other phase: hold.
- ct_taken, ct_rel, call, ret and eret are ignored outside WB_PH.
- Redirect takes effect on the WB clock edge; the next FETCH_PH uses the new pc.
- No alignment correction: a misaligned target is loaded as-is and misalign flags it. Trap decisions belong to the control unit.
- FETCH_PH == WB_PH is illegal.

Optional Feature:
Macro PC_RAS_EN.

With PC_RAS_EN defined, a RAS_DEPTH-entry circular stack operates in WB_PH when !stall && !trap && !eret && ct_taken:
- call=1: push ipc+STEP; pc target from dr/ct_rel as usual.
- ret=1, stack non-empty: pc <= top entry (dr ignored); pop.
- ret=1, stack empty: pc <= normal dr/ct_rel target; no pop; ras_empty stays 1.
- call and ret both 1: pop then push. pc <= popped value; stack depth unchanged; the top entry is replaced by ipc+STEP.
- Push when full: overwrite oldest entry; count saturates at RAS_DEPTH.
- ras_empty is updated in the same cycle as the push/pop.
- trap and eret do not touch the stack.

Without PC_RAS_EN:
- call and ret are ignored; ras_empty is tied to 1.
- No stack storage is synthesised.

Test Plan:
- Reset mid-run: n_rst low at 8 ns (async, between edges) → pc=0, ipc=0, epc=0 immediately. Release at 21 ns; FETCH_PH cycles → pc 4, 8, 12.
- Absolute and relative branch:
  - ipc=0x10, WB_PH, ct_taken=1, ct_rel=0, dr=0x100 → pc=0x100.
  - Next instruction, ct_rel=1, dr=0xFFFFFFF0 with ipc=0x100 → pc=0xF0.
- Trap priority and return: WB_PH with trap=1, ct_taken=1, dr=0x40, ipc=0x24 → pc=0x80, epc=0x24. A later WB_PH with eret=1 → pc=0x24.
- Stall and wrap: pc=0xFFFFFFFC, FETCH_PH with stall=1 → unchanged. stall=0 → pc=0, ipc=0xFFFFFFFC.
- Misalign: ct_taken, dr=0x102 → pc=0x102, misalign=1. Next fetch → pc=0x106, misalign still 1.
- PC_RAS_EN, RAS_DEPTH=4:
  - Five calls from ipc 0x00, 0x10, 0x20, 0x30, 0x40 → ras_empty=0.
  - Four rets → pc 0x44, 0x34, 0x24, 0x14.
  - A fifth ret with dr=0x200 → pc=0x200; ras_empty=1.
